// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX, TX and FIFO blocks.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: captures every DV-strobed byte and
// presents it on a first-word-fall-through valid/ready read port, with
// occupancy and a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_RX_DV,
  input  byte_t            i_RX_Byte,
  output byte_t            o_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Full,
  output logic             o_Overflow,
  input  logic             i_Clear_Overflow
);

  // DEPTH is a power of two, so the pointers wrap on their own.
  localparam int PTR_W = $clog2(DEPTH);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  logic valid;
  logic full;
  logic pop;
  logic write;
  logic drop;

  // Status comes only from registered state; the event decode uses it
  // so a full queue can still accept a byte when it pops the same cycle.
  assign valid = (count_reg != '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign pop   = valid & i_Ready;
  assign write = i_RX_DV & (~full | pop);
  assign drop  = i_RX_DV & full & ~pop;

  // Storage write; the array itself is never cleared, only the pointers.
  always_ff @(posedge i_Clk) begin
    if (write && !i_Reset) begin
      mem[wr_ptr_reg] <= i_RX_Byte;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything stored.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (write) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({write, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (i_Clear_Overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign o_Valid    = valid;
  assign o_Full     = full;
  assign o_Count    = count_reg;
  assign o_Overflow = overflow_reg;
  assign o_Data     = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo with a queue-based scoreboard.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rx_dv = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic [7:0]       data;
  logic             valid;
  logic             ready = 1'b0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;
  logic             clr = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] last_pop = 8'h00;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_RX_DV          (rx_dv),
    .i_RX_Byte        (rx_byte),
    .o_Data           (data),
    .o_Valid          (valid),
    .i_Ready          (ready),
    .o_Count          (count),
    .o_Full           (full),
    .o_Overflow       (overflow),
    .i_Clear_Overflow (clr)
  );

  // Drive one cycle of stimulus and advance the scoreboard model.
  task automatic step(input logic dv, input logic [7:0] b, input logic rdy,
                      input logic c, input logic r);
    logic m_pop, m_full, m_write, m_drop;
    m_pop   = (sb_q.size() != 0) && rdy;
    m_full  = (sb_q.size() == DEPTH);
    m_write = dv && (!m_full || m_pop);
    m_drop  = dv && m_full && !m_pop;
    rx_dv = dv; rx_byte = b; ready = rdy; clr = c; rst = r;
    @(posedge clk);
    #1;
    rx_dv = 1'b0; rx_byte = 8'h00; ready = 1'b0; clr = 1'b0; rst = 1'b0;
    if (r) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_pop) last_pop = sb_q.pop_front();
      if (m_write) sb_q.push_back(b);
      if (m_drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
    end
  endtask

  task automatic test_reset;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid !== 1'b0 || count !== '0 || data !== 8'h00 ||
          overflow !== 1'b0 || full !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: valid=%b count=%0d data=%h ovf=%b full=%b, want 0/0/00/0/0",
                 i, valid, count, data, overflow, full);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    $display("reset_idle checked");
  endtask

  task automatic test_single;
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    total++;
    if (valid !== 1'b1 || data !== 8'hA5 || count !== CNT_W'(1)) begin
      bad++;
      $display("FAIL single_write: valid=%b data=%h count=%0d, want 1/a5/1", valid, data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    total++;
    if (valid !== 1'b0 || count !== '0 || data !== 8'h00) begin
      bad++;
      $display("FAIL single_pop: valid=%b count=%0d data=%h, want 0/0/00", valid, count, data);
    end
    $display("single byte a5 written and popped");
  endtask

  task automatic test_fill_wrap;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    total++;
    if (full !== 1'b1 || count !== CNT_W'(DEPTH)) begin
      bad++;
      $display("FAIL fill: full=%b count=%0d, want 1/%0d", full, count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (valid !== 1'b1 || data !== 8'(i)) begin
        bad++;
        $display("FAIL drain_order idx=%0d: valid=%b data=%h, want 1/%h", i, valid, data, 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (count !== '0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL drained: count=%0d valid=%b, want 0/0", count, valid);
    end
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() != 0) begin
        total++;
        if (data !== sb_q[0]) begin
          bad++;
          $display("FAIL wrap_stream idx=%0d: data=%h, want %h", i, data, sb_q[0]);
        end
      end
      step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (count !== CNT_W'(sb_q.size())) begin
        bad++;
        $display("FAIL wrap_count idx=%0d: count=%0d, want %0d", i, count, sb_q.size());
      end
    end
    while (sb_q.size() != 0) begin
      total++;
      if (data !== sb_q[0]) begin
        bad++;
        $display("FAIL wrap_tail: data=%h, want %h", data, sb_q[0]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    $display("fill, drain and wrap stream done, last=%h", last_pop);
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    total++;
    if (overflow !== 1'b1 || count !== CNT_W'(DEPTH) || data !== 8'h80 || overflow !== m_ovf) begin
      bad++;
      $display("FAIL drop: ovf=%b count=%0d data=%h, want 1/%0d/80", overflow, count, data, DEPTH);
    end
    step(1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL drop_beats_clear: ovf=%b, want 1", overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clear: ovf=%b, want 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (data !== sb_q[0] || data !== 8'h80 + 8'(i)) begin
        bad++;
        $display("FAIL ovf_drain idx=%0d: data=%h, want %h", i, data, sb_q[0]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_empty: valid=%b, want 0", valid);
    end
    $display("overflow set, held against clear, cleared");
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    total++;
    if (count !== CNT_W'(DEPTH) || full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_pop: count=%0d full=%b ovf=%b, want %0d/1/0", count, full, overflow, DEPTH);
    end
    while (sb_q.size() != 0) begin
      total++;
      if (data !== sb_q[0]) begin
        bad++;
        $display("FAIL full_pop_drain: data=%h, want %h", data, sb_q[0]);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (last_pop !== 8'h55 || valid !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_last: last=%h valid=%b, want 55/0", last_pop, valid);
    end
    $display("full write with pop accepted 55");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== CNT_W'(5)) begin
      bad++;
      $display("FAIL mid_fill: count=%0d, want 5", count);
    end
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    total++;
    if (count !== '0 || valid !== 1'b0 || data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: count=%0d valid=%b data=%h, want 0/0/00", count, valid, data);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== '0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_hold: count=%0d valid=%b, want 0/0", count, valid);
    end
    $display("reset mid-stream discarded contents");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
